memwb_nor_bridge: RTL and testbench

Wishbone-pipelined slave that terminates the memory bus driven by the QSPI control FSM and serialises its requests onto the single-outstanding NOR array controller port. It buffers up to REQ_DEPTH pipelined requests, issues them to the NOR controller one at a time and returns in-order ack/err with read data. The bridge sits directly downstream of the QSPI FSM's `memwb_*` master and directly upstream of the NOR controller.

---
 rtl/memwb_nor_bridge_pkg.sv | 24 ++
 rtl/memwb_nor_bridge_fsfifo.sv | 58 +++++
 rtl/memwb_nor_bridge.sv | 195 +++++++++++++++++++
 tb/tb_memwb_nor_bridge.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_nor_bridge_pkg.sv
// Shared definitions for the Wishbone-to-NOR bridge.
// Holds the NOR bus widths, the bridge FSM state encoding and the helper
// that sizes the optional WAIT timeout counter (MEMWB_NOR_TIMEOUT_EN).
package memwb_nor_bridge_pkg;

    localparam int unsigned NOR_ADDR_BITS = 24;
    localparam int unsigned NOR_DATA_BITS = 16;
    localparam int unsigned TMO_MIN_BITS  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } bridge_state_t;

    // Timeout counter width: wide enough for the limit, never below 10 bits.
    function automatic int unsigned tmo_bits(input int unsigned cyc);
        int unsigned need;
        need = $clog2(cyc + 1);
        return (need > TMO_MIN_BITS) ? need : TMO_MIN_BITS;
    endfunction

endpackage

// File: rtl/memwb_nor_bridge_fsfifo.sv
// fsfifo: synchronous request queue for the bridge.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (also used as flush)
//   push, push_data   write one entry (ignored when full and not popping)
//   pop, head         drop the head entry; head is the current head word
//   full, empty       occupancy flags
//   count             number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module memwb_nor_bridge_fsfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot this cycle, so a push at full still fits.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/memwb_nor_bridge.sv
// memwb_nor_bridge: Wishbone-pipelined slave that queues requests from the
// QSPI control FSM and serialises them, one at a time, onto the NOR array
// controller, returning in-order ack/err with read data.
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   wb_cyc_i/stb_i/we_i/adr_i/dat_i  Wishbone pipelined request
//   wb_stall_o (combinational), wb_ack_o, wb_err_o, wb_dat_o   Wishbone response
//   nor_req_o, nor_we_o, nor_adr_o, nor_dat_o   NOR operation (fields held until done)
//   nor_busy_i, nor_done_i, nor_dat_i           NOR controller status / read data
//   pending_o                      queued + in-flight request count (debug)
// Optional feature: define MEMWB_NOR_TIMEOUT_EN to bound WAIT to TIMEOUT_CYC
// cycles and answer an expired operation with wb_err_o.
module memwb_nor_bridge
    import memwb_nor_bridge_pkg::*;
#(
    parameter int unsigned ADDRBITS    = NOR_ADDR_BITS,
    parameter int unsigned DATABITS    = NOR_DATA_BITS,
    parameter int unsigned REQ_DEPTH   = 4,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        wb_cyc_i,
    input  logic                        wb_stb_i,
    input  logic                        wb_we_i,
    input  logic [ADDRBITS-1:0]         wb_adr_i,
    input  logic [DATABITS-1:0]         wb_dat_i,
    output logic                        wb_stall_o,
    output logic                        wb_ack_o,
    output logic                        wb_err_o,
    output logic [DATABITS-1:0]         wb_dat_o,
    output logic                        nor_req_o,
    output logic                        nor_we_o,
    output logic [ADDRBITS-1:0]         nor_adr_o,
    output logic [DATABITS-1:0]         nor_dat_o,
    input  logic                        nor_busy_i,
    input  logic                        nor_done_i,
    input  logic [DATABITS-1:0]         nor_dat_i,
    output logic [$clog2(REQ_DEPTH):0]  pending_o
);

    localparam int unsigned QW = 1 + ADDRBITS + DATABITS;
    localparam int unsigned CW = $clog2(REQ_DEPTH) + 1;

    // Elaboration-time sanity check of the configuration.
    if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0 || TIMEOUT_CYC == 0) begin : g_bad_cfg
        $error("memwb_nor_bridge: REQ_DEPTH must be a power of two >= 2 and TIMEOUT_CYC > 0");
    end

    bridge_state_t       state;
    bridge_state_t       next_state;

    logic                fifo_rst_c;
    logic                push_c;
    logic                pop_c;
    logic [QW-1:0]       q_head;
    logic                q_full;
    logic                q_empty;
    logic [CW-1:0]       q_count;

    logic                abort_q;
    logic                suppress_c;
    logic [DATABITS-1:0] rd_data_q;
    logic                done_c;

    logic                req_d;
    logic                ack_d;
    logic                err_d;
    logic [DATABITS-1:0] dat_d;

    logic                tmo_hit_c;
    logic                tmo_err_q;

    // Dropping wb_cyc_i flushes every unissued entry immediately.
    assign fifo_rst_c = reset_i || !wb_cyc_i;
    assign wb_stall_o = q_full || !wb_cyc_i;
    assign push_c     = wb_cyc_i && wb_stb_i && !wb_stall_o;
    assign pending_o  = q_count + CW'(state != ST_IDLE);

    // An operation seen with wb_cyc_i low is still completed on the NOR side
    // but answered silently.
    assign suppress_c = abort_q || !wb_cyc_i;

    // Completion counts in ISSUE as well as WAIT.
    assign done_c = nor_done_i && (state == ST_ISSUE || state == ST_WAIT);

    memwb_nor_bridge_fsfifo #(
        .WIDTH (QW),
        .DEPTH (REQ_DEPTH)
    ) u_fsfifo (
        .clk       (clk_i),
        .rst       (fifo_rst_c),
        .push      (push_c),
        .push_data ({wb_we_i, wb_adr_i, wb_dat_i}),
        .pop       (pop_c),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

`ifdef MEMWB_NOR_TIMEOUT_EN
    localparam int unsigned TMO_W = tmo_bits(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit_c = (state == ST_WAIT) && !nor_done_i &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // WAIT cycle counter; cleared while issuing so it starts at 0 in WAIT.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else if (state == ST_ISSUE) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else if (state == ST_WAIT) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit_c) tmo_err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit_c = 1'b0;
    assign tmo_err_q = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        next_state = state;
        pop_c      = 1'b0;
        req_d      = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dat_d      = '0;
        case (state)
            ST_IDLE: begin
                if (!q_empty && !nor_busy_i) begin
                    pop_c      = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                req_d      = 1'b1;
                next_state = nor_done_i ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (nor_done_i || tmo_hit_c) next_state = ST_RESP;
            end
            ST_RESP: begin
                next_state = ST_IDLE;
                if (!suppress_c) begin
                    if (tmo_err_q) begin
                        err_d = 1'b1;
                    end else begin
                        ack_d = 1'b1;
                        dat_d = rd_data_q;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Operation registers, response registers and abort tracking.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            nor_req_o <= 1'b0;
            nor_we_o  <= 1'b0;
            nor_adr_o <= '0;
            nor_dat_o <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= '0;
            rd_data_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            nor_req_o <= req_d;
            wb_ack_o  <= ack_d;
            wb_err_o  <= err_d;
            wb_dat_o  <= dat_d;
            if (pop_c) {nor_we_o, nor_adr_o, nor_dat_o} <= q_head;
            if (done_c) rd_data_q <= nor_we_o ? '0 : nor_dat_i;
            if (next_state == ST_IDLE)                 abort_q <= 1'b0;
            else if (!wb_cyc_i && state != ST_IDLE)    abort_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memwb_nor_bridge.sv
// Self-checking bench for memwb_nor_bridge: directed vector table, multi-cycle
// corner sequences (abort, reset in WAIT, optional timeout) and a randomised
// run against an in-order queue model with a behavioural NOR responder.
module tb_memwb_nor_bridge;
    import memwb_nor_bridge_pkg::*;

    localparam int unsigned AW    = NOR_ADDR_BITS;
    localparam int unsigned DW    = NOR_DATA_BITS;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [AW-1:0] adr = '0;
    logic [DW-1:0] wdat = '0;
    logic          stall, ack, err;
    logic [DW-1:0] rdat;
    logic          nor_req_o, nor_we_o;
    logic [AW-1:0] nor_adr_o;
    logic [DW-1:0] nor_dat_o;
    logic [PW-1:0] pending_o;

    logic          dir_busy = 1'b0, rnd_busy = 1'b0, rnd_busy_en = 1'b0;
    logic          dir_done = 1'b0, resp_done = 1'b0;
    logic [DW-1:0] dir_dat = '0, resp_dat = '0;
    logic          nor_busy, nor_done;
    logic [DW-1:0] nor_dat;

    assign nor_busy = dir_busy | rnd_busy;
    assign nor_done = dir_done | resp_done;
    assign nor_dat  = dir_dat | resp_dat;

    always #5 clk = ~clk;

    memwb_nor_bridge #(
        .ADDRBITS(AW), .DATABITS(DW), .REQ_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_stall_o(stall), .wb_ack_o(ack), .wb_err_o(err), .wb_dat_o(rdat),
        .nor_req_o(nor_req_o), .nor_we_o(nor_we_o), .nor_adr_o(nor_adr_o), .nor_dat_o(nor_dat_o),
        .nor_busy_i(nor_busy), .nor_done_i(nor_done), .nor_dat_i(nor_dat),
        .pending_o(pending_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural NOR array content as seen by reads.
    function automatic logic [DW-1:0] nor_rd(input logic [AW-1:0] a);
        logic [AW-1:0] m;
        m = a * AW'(7);
        return DW'(m) ^ DW'(16'hA5C3);
    endfunction

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } req_t;

    req_t iss_q[$];
    req_t ack_q[$];
    bit   mon_en = 0;
    bit   resp_en = 0;
    int   accepted = 0;
    int   completed = 0;
    int   max_pend = 0;
    bit   saw_stall = 0;

    // Push one Wishbone request, retrying while stalled; records it in the model.
    task automatic wb_push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int tries;
        bit got;
        req_t r;
        tries = 0;
        got = 0;
        stb = 1'b1; we = w; adr = a; wdat = d;
        while (!got && tries < 200) begin
            #1;
            if (!stall) begin
                got = 1;
                accepted++;
                r.we = w; r.adr = a; r.dat = d;
                if (mon_en) begin
                    iss_q.push_back(r);
                    ack_q.push_back(r);
                end
            end else if (cyc) begin
                saw_stall = 1;
            end
            tick();
            tries++;
        end
        stb = 1'b0;
        check("push_accepted", 32'(got), 32'd1);
    endtask

    // Random NOR responder: answers each request after 0..3 idle cycles.
    initial begin
        int d;
        forever begin
            @(posedge clk); #1;
            if (resp_en && nor_req_o) begin
                d = $urandom_range(0, 3);
                repeat (d) begin @(posedge clk); #1; end
                resp_done = 1'b1;
                resp_dat  = nor_we_o ? DW'($urandom) : nor_rd(nor_adr_o);
                @(posedge clk); #1;
                resp_done = 1'b0;
                resp_dat  = '0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            rnd_busy = rnd_busy_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // Scoreboard: issue order, response order/data and pending count.
    initial begin
        req_t r;
        forever begin
            @(posedge clk); #1;
            if (mon_en) begin
                if (nor_req_o) begin
                    check("issue_expected", 32'(iss_q.size() != 0), 32'd1);
                    if (iss_q.size() != 0) begin
                        r = iss_q.pop_front();
                        check("issue_adr", 32'(nor_adr_o), 32'(r.adr));
                        check("issue_we", 32'(nor_we_o), 32'(r.we));
                        if (r.we) check("issue_wdat", 32'(nor_dat_o), 32'(r.dat));
                    end
                end
                if (ack || err) begin
                    completed++;
                    check("resp_expected", 32'(ack_q.size() != 0), 32'd1);
                    if (ack_q.size() != 0) begin
                        r = ack_q.pop_front();
                        check("resp_is_ack", 32'(err), 32'd0);
                        check("resp_dat", 32'(rdat), r.we ? 32'd0 : 32'(nor_rd(r.adr)));
                    end
                end
                check("pending", 32'(pending_o), 32'(accepted - completed));
                if (int'(pending_o) > max_pend) max_pend = int'(pending_o);
            end
        end
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdat;
        logic [DW-1:0] nor_rdat;
        int            busy;
        logic [DW-1:0] exp_dat;
        int            exp_req_lat;
    } vec_t;

    vec_t vecs[4];

    task automatic wait_req(output int k);
        k = 0;
        while (!nor_req_o && k < 60) begin tick(); k++; end
    endtask

    initial begin
        int  k;
        bit  saw;
        vecs[0] = '{1'b0, 24'h000123, 16'h0000, 16'hBEEF, 0, 16'hBEEF, 2};
        vecs[1] = '{1'b1, 24'h000010, 16'h00F0, 16'h1234, 5, 16'h0000, 7};
        vecs[2] = '{1'b0, 24'hFFFFFF, 16'h0000, 16'hFFFF, 1, 16'hFFFF, 3};
        vecs[3] = '{1'b1, 24'h000000, 16'hFFFF, 16'hAAAA, 0, 16'h0000, 2};

        // Reset state.
        repeat (2) tick();
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rdat", 32'(rdat), 0);
        check("rst_req", 32'(nor_req_o), 0);
        check("rst_we", 32'(nor_we_o), 0);
        check("rst_adr", 32'(nor_adr_o), 0);
        check("rst_ndat", 32'(nor_dat_o), 0);
        check("rst_pending", 32'(pending_o), 0);
        check("rst_stall_cyc_low", 32'(stall), 1);
        cyc = 1'b1; #1;
        check("rst_stall_cyc_high", 32'(stall), 0);
        reset = 1'b0;
        tick();

        // Single-transaction vector table.
        for (int i = 0; i < 4; i++) begin
            dir_busy = (vecs[i].busy > 0);
            wb_push(vecs[i].we, vecs[i].adr, vecs[i].wdat);
            k = 0;
            do begin
                if (k >= vecs[i].busy) dir_busy = 1'b0;
                tick();
                k++;
            end while (!nor_req_o && k < 60);
            check("vec_req_latency", 32'(k), 32'(vecs[i].exp_req_lat));
            check("vec_nor_we", 32'(nor_we_o), 32'(vecs[i].we));
            check("vec_nor_adr", 32'(nor_adr_o), 32'(vecs[i].adr));
            if (vecs[i].we) check("vec_nor_dat", 32'(nor_dat_o), 32'(vecs[i].wdat));
            tick();
            check("vec_req_one_cycle", 32'(nor_req_o), 0);
            dir_done = 1'b1; dir_dat = vecs[i].nor_rdat;
            tick();
            dir_done = 1'b0; dir_dat = '0;
            check("vec_ack_not_early", 32'(ack), 0);
            tick();
            check("vec_ack", 32'(ack), 1);
            check("vec_rdat", 32'(rdat), 32'(vecs[i].exp_dat));
            check("vec_err", 32'(err), 0);
            tick();
            check("vec_ack_one_cycle", 32'(ack), 0);
            check("vec_pending_idle", 32'(pending_o), 0);
        end

        // Abort: three queued, one in WAIT, then cyc drops and comes back.
        for (int i = 0; i < 4; i++) wb_push(1'b0, AW'(24'h200 + i), '0);
        check("abort_pending_before", 32'(pending_o), 4);
        cyc = 1'b0; #1;
        check("abort_flush_pending", 32'(pending_o), 1);
        check("abort_stall", 32'(stall), 1);
        tick(); tick();
        cyc = 1'b1;
        wb_push(1'b0, 24'h000300, '0);
        check("abort_requeue_pending", 32'(pending_o), 2);
        tick(); tick();
        check("abort_no_early_issue", 32'(nor_req_o), 0);
        dir_done = 1'b1; dir_dat = 16'hDEAD;
        tick();
        dir_done = 1'b0; dir_dat = '0;
        k = 0; saw = 0;
        while (!nor_req_o && k < 20) begin
            if (ack || err) saw = 1;
            tick(); k++;
        end
        check("abort_suppressed_resp", 32'(saw), 0);
        check("abort_next_req_lat", 32'(k), 3);
        check("abort_next_adr", 32'(nor_adr_o), 32'h300);
        tick();
        dir_done = 1'b1; dir_dat = 16'h5A5A;
        tick();
        dir_done = 1'b0; dir_dat = '0;
        tick();
        check("abort_recover_ack", 32'(ack), 1);
        check("abort_recover_dat", 32'(rdat), 32'h5A5A);
        tick();
        check("abort_pending_zero", 32'(pending_o), 0);

        // Reset asserted while in WAIT.
        wb_push(1'b1, 24'h0ABCDE, 16'h1357);
        wait_req(k);
        check("rstwait_req_seen", 32'(nor_req_o), 1);
        tick();
        #2 reset = 1'b1;
        #1;
        check("rstwait_req", 32'(nor_req_o), 0);
        check("rstwait_we", 32'(nor_we_o), 0);
        check("rstwait_adr", 32'(nor_adr_o), 0);
        check("rstwait_ndat", 32'(nor_dat_o), 0);
        check("rstwait_ack", 32'(ack), 0);
        check("rstwait_err", 32'(err), 0);
        check("rstwait_rdat", 32'(rdat), 0);
        check("rstwait_pending", 32'(pending_o), 0);
        check("rstwait_stall", 32'(stall), 0);
        #1 reset = 1'b0;
        tick();
        dir_done = 1'b1; dir_dat = 16'h4444;
        tick();
        dir_done = 1'b0; dir_dat = '0;
        saw = 0;
        for (int i = 0; i < 4; i++) begin
            if (ack || err || nor_req_o) saw = 1;
            tick();
        end
        check("rstwait_stray_done", 32'(saw), 0);
        check("rstwait_pending_after", 32'(pending_o), 0);

`ifdef MEMWB_NOR_TIMEOUT_EN
        // Timeout: withhold done, expect err then the next entry to issue.
        wb_push(1'b0, 24'h000040, '0);
        wb_push(1'b0, 24'h000041, '0);
        wait_req(k);
        check("tmo_first_adr", 32'(nor_adr_o), 32'h40);
        k = 0; saw = 0;
        while (!err && k < 100) begin
            if (ack) saw = 1;
            tick(); k++;
        end
        check("tmo_err_latency", 32'(k), 32'(TMO + 1));
        check("tmo_err_dat", 32'(rdat), 0);
        check("tmo_no_ack", 32'(saw), 0);
        wait_req(k);
        check("tmo_next_req_lat", 32'(k), 2);
        check("tmo_next_adr", 32'(nor_adr_o), 32'h41);
        tick();
        dir_done = 1'b1; dir_dat = 16'h7777;
        tick();
        dir_done = 1'b0; dir_dat = '0;
        tick();
        check("tmo_next_ack", 32'(ack), 1);
        check("tmo_next_dat", 32'(rdat), 32'h7777);
        tick();
`endif

        // Pipelined burst of 6 reads against the scoreboard.
        accepted = 0; completed = 0; max_pend = 0; saw_stall = 0;
        mon_en = 1; resp_en = 1;
        tick();
        for (int i = 0; i < 6; i++) wb_push(1'b0, AW'(24'h1000 + i), '0);
        k = 0;
        while (completed != accepted && k < 500) begin tick(); k++; end
        check("burst_all_acked", 32'(completed), 6);
        check("burst_stalled", 32'(saw_stall), 1);
        check("burst_max_pending", 32'(max_pend), 5);

        // Randomised traffic with random busy and response delays.
        rnd_busy_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wb_push(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), DW'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        k = 0;
        while (completed != accepted && k < 3000) begin tick(); k++; end
        check("random_drained", 32'(completed), 32'(accepted));
        check("random_queues_empty", 32'(iss_q.size() + ack_q.size()), 0);
        rnd_busy_en = 1'b0;
        tick();
        mon_en = 0; resp_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
